ps_mul_issue: RTL and testbench
===============================

// Module: ps_mul_issue
// PURPOSE
//  Program-sequencer-side driver of the multiplier control interface. It accepts decoded
//  multiplier instructions, drives ps_mul_en/otreg/dtsts/cls and the register-file read and
//  write addresses in step with the multiplier's one-cycle latch. It interlocks Rn->Rx/Ry
//  read-after-write hazards and captures mul_ps_mv/mul_ps_mn into MV, MN and sticky MOS bits.
// PARAMETERS
//  RF_DATASIZE  16  data width of the multiplier/RF. Informational; no datapath in this block.
//  RF_ADDRW     4   register-file address width (16 registers).
// PORTS
//  clk           in   1           system clock; all state changes on posedge
//  rst_n         in   1           asynchronous, active-low reset
//  instr_valid   in   1           instr holds a multiplier instruction
//  instr         in   7+3*RF_ADDRW  {cls[1:0],otreg,dtsts[3:0],Rn,Rx,Ry}, MSB first
//  instr_ready   out  1           block accepts instr at this edge
//  flush         in   1           discard accepted and in-flight instructions
//  ps_mul_en     out  1           multiplier enable (one cycle per instruction)
//  ps_mul_otreg  out  1           0 = result to Rn, 1 = result to MR
//  ps_mul_dtsts  out  4           {ryUbS,rxUbS,IbF,rnd}
//  ps_mul_cls    out  2           00 SAT, 01 product, 10 MR+=, 11 MR-=
//  ps_xb_rdx     out  RF_ADDRW    Rx read address (valid while ps_mul_en)
//  ps_xb_rdy     out  RF_ADDRW    Ry read address (valid while ps_mul_en)
//  ps_xb_wen     out  1           write mul_xb_dt into Rn at this edge
//  ps_xb_wraddr  out  RF_ADDRW    Rn write address
//  mul_ps_mv     in   1           multiplier overflow flag (valid in result cycle)
//  mul_ps_mn     in   1           multiplier sign flag (valid in result cycle)
//  mstat_clr     in   1           clear MOS sticky bit
//  astat_mv      out  1           MV of last completed instruction
//  astat_mn      out  1           MN of last completed instruction
//  sticky_mos    out  1           OR of all MV since reset/clear
//  illegal       out  1           one-cycle pulse: rejected illegal encoding
// BEHAVIOUR
//  - Reset: all outputs 0 except instr_ready=1; pipeline empty. Async assert, sync deassert.
//  - Pipeline stages: ACC edge E0 (instr_valid&instr_ready). ISSUE cycle = cycle after E0:
//    ps_mul_* and rdx/rdy are driven from flops, ps_mul_en=1. The multiplier latches at E1.
//    RESULT cycle = cycle after E1: mul_xb_dt and flags are valid. At E2, Rn is written and
//    the flags are captured. Throughput is one instruction per cycle when no hazard exists.
//  - ps_mul_en=0 in every cycle without an issue. The other ps_mul_* outputs hold their last
//    value.
//  - ps_xb_wen=1 in RESULT cycle iff otreg=0 (SAT with otreg=0 included); ps_xb_wraddr=Rn.
//  - Flags: at E2 of every completed instruction astat_mv<=mv, astat_mn<=mn,
//    sticky_mos<=sticky_mos|mv. When mstat_clr and a completion coincide, the new mv still
//    sets MOS (clear first, then OR).
//  - Hazard: candidate B conflicts with ISSUE instruction A iff A.otreg=0, B.cls!=00, and
//    (B.Rx==A.Rn or B.Ry==A.Rn). On conflict instr_ready=0 for that cycle. B is accepted one
//    edge later and reads the RF after A's write. No conflict exists with the RESULT stage;
//    MR-to-MR chaining never stalls.
//  - Illegal dtsts: rnd=1 with IbF=0 (xx01). Such an instr is accepted (ready=1), not issued,
//    and pulses illegal in the following cycle. No RF, MR, or flag effect.
//  - flush: at the edge where flush=1, the ISSUE and RESULT stages are cleared. ps_mul_en and
//    ps_xb_wen are 0 the next cycle and flags do not update. instr_ready=0 while flush=1.
//  - rst_n low mid-operation: pending write and flag update are dropped; no partial write.
// TESTING
//  1 Product UUI cls=01,otreg=0,dtsts=0000,Rn=3,Rx=1,Ry=2 accepted at E0 -> ps_mul_en=1
//    cycle1, rdx=1,rdy=2; ps_xb_wen=1,wraddr=3 cycle2.
//  2 Back-to-back A(Rn=5) then B(Rx=5): instr_ready=0 one cycle; B ps_mul_en two cycles after
//    A; B(Rx=6) instead: no stall.
//  3 MR accumulate chain cls=10,otreg=1 x4 consecutive -> ready always 1, ps_xb_wen never 1,
//    ps_mul_en high 4 cycles.
//  4 mul_ps_mv=1 in one result cycle, then 0 -> astat_mv 1 then 0; sticky_mos stays 1 until
//    mstat_clr; clr coincident with mv=1 -> MOS=1.
//  5 dtsts=0001 -> illegal pulses 1 cycle, ps_mul_en stays 0, no write.
//  6 flush in ISSUE cycle of otreg=0 instr -> no ps_xb_wen, flags unchanged; rst_n low in
//    RESULT cycle -> all outputs 0 and instr_ready=1.

Source files
------------

// File: rtl/ps_mul_issue.sv
// ps_mul_issue: issues decoded multiplier instructions, sequences RF read/write addresses,
// interlocks Rn->Rx/Ry hazards against the ISSUE stage and captures MV/MN/MOS flags.
module ps_mul_issue #(
    parameter int RF_DATASIZE = 16,
    parameter int RF_ADDRW    = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      instr_valid,
    input  logic [7+3*RF_ADDRW-1:0]   instr,
    output logic                      instr_ready,
    input  logic                      flush,
    output logic                      ps_mul_en,
    output logic                      ps_mul_otreg,
    output logic [3:0]                ps_mul_dtsts,
    output logic [1:0]                ps_mul_cls,
    output logic [RF_ADDRW-1:0]       ps_xb_rdx,
    output logic [RF_ADDRW-1:0]       ps_xb_rdy,
    output logic                      ps_xb_wen,
    output logic [RF_ADDRW-1:0]       ps_xb_wraddr,
    input  logic                      mul_ps_mv,
    input  logic                      mul_ps_mn,
    input  logic                      mstat_clr,
    output logic                      astat_mv,
    output logic                      astat_mn,
    output logic                      sticky_mos,
    output logic                      illegal
);
    localparam int IW = 7 + 3 * RF_ADDRW;

    if (RF_DATASIZE < 1 || RF_ADDRW < 1) begin : g_bad_param
        $error("ps_mul_issue: RF_DATASIZE and RF_ADDRW must be positive");
    end

    logic [1:0]          cls;
    logic                otreg;
    logic [3:0]          dtsts;
    logic [RF_ADDRW-1:0] rn, rx, ry;
    logic [RF_ADDRW-1:0] iss_rn;
    logic                hazard, accept, bad, res_v, done;

    assign cls   = instr[IW-1 -: 2];
    assign otreg = instr[IW-3];
    assign dtsts = instr[IW-4 -: 4];
    assign rn    = instr[3*RF_ADDRW-1 -: RF_ADDRW];
    assign rx    = instr[2*RF_ADDRW-1 -: RF_ADDRW];
    assign ry    = instr[RF_ADDRW-1:0];

    // Only the ISSUE stage can conflict: by the time B issues, A's result has been written.
    always_comb begin
        hazard      = ps_mul_en & ~ps_mul_otreg & (cls != 2'b00) & ((rx == iss_rn) | (ry == iss_rn));
        instr_ready = ~flush & ~hazard;
        accept      = instr_valid & instr_ready;
        bad         = dtsts[1:0] == 2'b01;
        done        = res_v & ~flush;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ps_mul_en    <= 1'b0;
            ps_mul_otreg <= 1'b0;
            ps_mul_dtsts <= '0;
            ps_mul_cls   <= '0;
            ps_xb_rdx    <= '0;
            ps_xb_rdy    <= '0;
            iss_rn       <= '0;
            ps_xb_wen    <= 1'b0;
            ps_xb_wraddr <= '0;
            res_v        <= 1'b0;
            astat_mv     <= 1'b0;
            astat_mn     <= 1'b0;
            sticky_mos   <= 1'b0;
            illegal      <= 1'b0;
        end else begin
            ps_mul_en <= accept & ~bad;
            illegal   <= accept & bad;
            if (accept & ~bad) begin
                ps_mul_cls   <= cls;
                ps_mul_otreg <= otreg;
                ps_mul_dtsts <= dtsts;
                ps_xb_rdx    <= rx;
                ps_xb_rdy    <= ry;
                iss_rn       <= rn;
            end
            res_v     <= ps_mul_en & ~flush;
            ps_xb_wen <= ps_mul_en & ~ps_mul_otreg & ~flush;
            if (ps_mul_en)
                ps_xb_wraddr <= iss_rn;
            if (done) begin
                astat_mv <= mul_ps_mv;
                astat_mn <= mul_ps_mn;
            end
            // Clear applies before the OR so a coincident overflow still sets MOS.
            sticky_mos <= (sticky_mos & ~mstat_clr) | (done & mul_ps_mv);
        end
    end
endmodule

// File: tb/tb_ps_mul_issue.sv
// tb_ps_mul_issue: directed vectors; expected issue/write/illegal events go into queues and a
// negedge monitor pops and compares them against what the DUT presents.
module tb_ps_mul_issue;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        instr_valid = 1'b0;
    logic [18:0] instr = '0;
    logic        instr_ready;
    logic        flush = 1'b0;
    logic        ps_mul_en, ps_mul_otreg, ps_xb_wen;
    logic [3:0]  ps_mul_dtsts;
    logic [1:0]  ps_mul_cls;
    logic [3:0]  ps_xb_rdx, ps_xb_rdy, ps_xb_wraddr;
    logic        mul_ps_mv = 1'b0, mul_ps_mn = 1'b0, mstat_clr = 1'b0;
    logic        astat_mv, astat_mn, sticky_mos, illegal;

    ps_mul_issue #(.RF_DATASIZE(16), .RF_ADDRW(4)) dut (
        .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr(instr),
        .instr_ready(instr_ready), .flush(flush), .ps_mul_en(ps_mul_en),
        .ps_mul_otreg(ps_mul_otreg), .ps_mul_dtsts(ps_mul_dtsts), .ps_mul_cls(ps_mul_cls),
        .ps_xb_rdx(ps_xb_rdx), .ps_xb_rdy(ps_xb_rdy), .ps_xb_wen(ps_xb_wen),
        .ps_xb_wraddr(ps_xb_wraddr), .mul_ps_mv(mul_ps_mv), .mul_ps_mn(mul_ps_mn),
        .mstat_clr(mstat_clr), .astat_mv(astat_mv), .astat_mn(astat_mn),
        .sticky_mos(sticky_mos), .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        int         cyc;
        logic [1:0] cls;
        logic       ot;
        logic [3:0] dt;
        logic [3:0] rx;
        logic [3:0] ry;
    } iss_t;
    typedef struct packed {
        int         cyc;
        logic [3:0] addr;
    } wr_t;

    iss_t iq[$];
    wr_t  wq[$];
    int   lq[$];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    iss_t ie;
    wr_t  we;
    int   le;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [18:0] mk(input logic [1:0] c, input logic o, input logic [3:0] d,
                                       input logic [3:0] n, input logic [3:0] x, input logic [3:0] y);
        return {c, o, d, n, x, y};
    endfunction

    // Present ins until accepted; expect exp_stall cycles of ready=0 first.
    task automatic send(input logic [18:0] ins, input int exp_stall, input bit wr_expected);
        int st = 0;
        bit ok = 0;
        iss_t e;
        wr_t w;
        instr = ins;
        instr_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (instr_ready) begin ok = 1; break; end
            st++;
        end
        if (!ok) chk("accept_timeout", 0, 1);
        chk("stall_cycles", st, exp_stall);
        if (ok) begin
            if (ins[13:12] == 2'b01) lq.push_back(cyc + 1);
            else begin
                e = '{cyc + 1, ins[18:17], ins[16], ins[15:12], ins[7:4], ins[3:0]};
                iq.push_back(e);
                if (wr_expected && !ins[16]) begin
                    w = '{cyc + 2, ins[11:8]};
                    wq.push_back(w);
                end
            end
        end
        @(posedge clk); #1;
        instr_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    always @(negedge clk) begin
        if (ps_mul_en) begin
            if (iq.size() == 0) chk("unexpected_issue", 1, 0);
            else begin
                ie = iq.pop_front();
                chk("issue_cycle", cyc, ie.cyc);
                chk("issue_cls", {30'd0, ps_mul_cls}, {30'd0, ie.cls});
                chk("issue_otreg", {31'd0, ps_mul_otreg}, {31'd0, ie.ot});
                chk("issue_dtsts", {28'd0, ps_mul_dtsts}, {28'd0, ie.dt});
                chk("issue_rdx", {28'd0, ps_xb_rdx}, {28'd0, ie.rx});
                chk("issue_rdy", {28'd0, ps_xb_rdy}, {28'd0, ie.ry});
            end
        end
        if (ps_xb_wen) begin
            if (wq.size() == 0) chk("unexpected_write", 1, 0);
            else begin
                we = wq.pop_front();
                chk("write_cycle", cyc, we.cyc);
                chk("write_addr", {28'd0, ps_xb_wraddr}, {28'd0, we.addr});
            end
        end
        if (illegal) begin
            if (lq.size() == 0) chk("unexpected_illegal", 1, 0);
            else begin
                le = lq.pop_front();
                chk("illegal_cycle", cyc, le);
            end
        end
    end

    task automatic chk_reset_state(input string tag);
        chk({tag, "_ready"}, {31'd0, instr_ready}, 1);
        chk({tag, "_outs"}, {ps_mul_en, ps_mul_otreg, ps_mul_dtsts, ps_mul_cls, ps_xb_wen,
                             astat_mv, astat_mn, sticky_mos, illegal}, 0);
        chk({tag, "_addrs"}, {ps_xb_rdx, ps_xb_rdy, ps_xb_wraddr}, 0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk_reset_state("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(1);
        // product to Rn=3 reading R1,R2
        send(mk(2'b01, 0, 4'b0000, 4'd3, 4'd1, 4'd2), 0, 1);
        idle(3);
        // RAW on Rx stalls one cycle; unrelated Rx does not
        send(mk(2'b01, 0, 4'b0000, 4'd5, 4'd1, 4'd2), 0, 1);
        send(mk(2'b01, 0, 4'b0000, 4'd8, 4'd5, 4'd7), 1, 1);
        idle(3);
        send(mk(2'b01, 0, 4'b0000, 4'd5, 4'd1, 4'd2), 0, 1);
        send(mk(2'b01, 0, 4'b0000, 4'd8, 4'd6, 4'd7), 0, 1);
        idle(3);
        // RAW on Ry, and SAT (cls=00) never interlocks
        send(mk(2'b01, 0, 4'b1000, 4'd9, 4'd1, 4'd2), 0, 1);
        send(mk(2'b11, 0, 4'b0000, 4'd4, 4'd3, 4'd9), 1, 1);
        send(mk(2'b00, 0, 4'b0000, 4'd4, 4'd4, 4'd4), 0, 1);
        idle(3);
        // MR accumulate chain, Rx equal to previous Rn on purpose
        for (int i = 0; i < 4; i++)
            send(mk(2'b10, 1, 4'b0000, 4'(i + 1), 4'(i), 4'd2), 0, 1);
        idle(3);
        // flags
        send(mk(2'b01, 0, 4'b0000, 4'd4, 4'd1, 4'd2), 0, 1);
        idle(1);
        mul_ps_mv = 1'b1; mul_ps_mn = 1'b1;
        idle(1);
        mul_ps_mv = 1'b0; mul_ps_mn = 1'b0;
        chk("mv_set", {31'd0, astat_mv}, 1);
        chk("mn_set", {31'd0, astat_mn}, 1);
        chk("mos_set", {31'd0, sticky_mos}, 1);
        send(mk(2'b01, 0, 4'b0000, 4'd4, 4'd1, 4'd2), 0, 1);
        idle(2);
        chk("mv_cleared_by_next", {31'd0, astat_mv}, 0);
        chk("mn_cleared_by_next", {31'd0, astat_mn}, 0);
        chk("mos_sticky", {31'd0, sticky_mos}, 1);
        mstat_clr = 1'b1;
        idle(1);
        mstat_clr = 1'b0;
        chk("mos_clr", {31'd0, sticky_mos}, 0);
        send(mk(2'b01, 1, 4'b0000, 4'd4, 4'd1, 4'd2), 0, 1);
        idle(1);
        mul_ps_mv = 1'b1; mstat_clr = 1'b1;
        idle(1);
        mul_ps_mv = 1'b0; mstat_clr = 1'b0;
        chk("mos_clr_coincident", {31'd0, sticky_mos}, 1);
        chk("mv_clr_coincident", {31'd0, astat_mv}, 1);
        mstat_clr = 1'b1;
        idle(1);
        mstat_clr = 1'b0;
        send(mk(2'b01, 0, 4'b0000, 4'd4, 4'd1, 4'd2), 0, 1);
        idle(3);
        chk("flags_quiet", {29'd0, astat_mv, astat_mn, sticky_mos}, 0);
        // illegal rnd without IbF; rnd with IbF is legal
        send(mk(2'b01, 0, 4'b0001, 4'd9, 4'd1, 4'd2), 0, 1);
        idle(3);
        send(mk(2'b01, 0, 4'b0011, 4'd9, 4'd1, 4'd2), 0, 1);
        idle(3);
        // flush in ISSUE cycle: issue seen, no write, no flag update
        send(mk(2'b01, 0, 4'b0000, 4'd10, 4'd1, 4'd2), 0, 0);
        flush = 1'b1;
        @(negedge clk);
        chk("ready_during_flush", {31'd0, instr_ready}, 0);
        @(posedge clk); #1;
        flush = 1'b0;
        mul_ps_mv = 1'b1; mul_ps_mn = 1'b1;
        idle(2);
        mul_ps_mv = 1'b0; mul_ps_mn = 1'b0;
        chk("flush_flags", {29'd0, astat_mv, astat_mn, sticky_mos}, 0);
        // reset during RESULT cycle drops the write and flag update
        send(mk(2'b01, 0, 4'b0000, 4'd11, 4'd1, 4'd2), 0, 0);
        @(posedge clk);
        mul_ps_mv = 1'b1;
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk_reset_state("midreset");
        @(posedge clk); #1;
        mul_ps_mv = 1'b0;
        rst_n = 1'b1;
        idle(3);
        chk("midreset_flags", {29'd0, astat_mv, astat_mn, sticky_mos}, 0);
        chk("issue_queue_empty", iq.size(), 0);
        chk("write_queue_empty", wq.size(), 0);
        chk("illegal_queue_empty", lq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
